// File: rtl/jtdd_adpcm_fetch_pkg.sv
// Shared types for the ADPCM sample-ROM fetch stage.
package jtdd_adpcm_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_FETCH        = 2'd1,
        ST_WAIT_DISCARD = 2'd2
    } fetch_state_e;

    typedef enum logic {
        KIND_CUR = 1'b0,
        KIND_NXT = 1'b1
    } fetch_kind_e;

    localparam logic [7:0] MISS_MAX = 8'hFF;

endpackage

// File: rtl/jtdd_adpcm_fetch_slot.sv
// One cached ROM byte: tag, data byte and valid flag, plus an address compare.
module jtdd_adpcm_fetch_slot #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_i,
    input  logic          clr_i,
    input  logic [AW-1:0] wr_tag_i,
    input  logic [7:0]    wr_byte_i,
    input  logic [AW-1:0] cmp_addr_i,
    output logic [AW-1:0] tag_o,
    output logic [7:0]    byte_o,
    output logic          valid_o,
    output logic          hit_o
);

    logic [AW-1:0] tag_q;
    logic [7:0]    byte_q;
    logic          valid_q;

    // A write always leaves the slot valid; a clear only drops the valid flag and keeps the tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
        end else if (wr_i) begin
            tag_q   <= wr_tag_i;
            byte_q  <= wr_byte_i;
            valid_q <= 1'b1;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end
    end

    assign tag_o   = tag_q;
    assign byte_o  = byte_q;
    assign valid_o = valid_q;
    assign hit_o   = valid_q && (tag_q == cmp_addr_i);

endmodule

// File: rtl/jtdd_adpcm_fetch.sv
// ROM byte fetcher for the ADPCM decoder: holds the current byte and prefetches the next one.
module jtdd_adpcm_fetch
    import jtdd_adpcm_fetch_pkg::*;
#(
    parameter int AW       = 16,
    parameter int PREFETCH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic          cs,
    output logic [7:0]    data,
    output logic          ok,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    input  logic [7:0]    mem_data,
    input  logic          mem_dok,
    output logic [7:0]    miss_cnt
);

    fetch_state_e  state_q, state_d;
    fetch_kind_e   kind_q, kind_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_req_q, mem_req_d;
    logic [7:0]    miss_q, miss_d;

    logic [AW-1:0] cur_tag, nxt_tag, cur_inc;
    logic [7:0]    cur_byte, nxt_byte;
    logic          cur_valid, nxt_valid, cur_hit, nxt_hit;

    logic          cur_wr, cur_clr, nxt_wr, nxt_clr;
    logic [AW-1:0] cur_wr_tag, nxt_wr_tag;
    logic [7:0]    cur_wr_byte, nxt_wr_byte;

    assign cur_inc = cur_tag + AW'(1);

    jtdd_adpcm_fetch_slot #(.AW(AW)) u_cur (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_i       (cur_wr),
        .clr_i      (cur_clr),
        .wr_tag_i   (cur_wr_tag),
        .wr_byte_i  (cur_wr_byte),
        .cmp_addr_i (addr),
        .tag_o      (cur_tag),
        .byte_o     (cur_byte),
        .valid_o    (cur_valid),
        .hit_o      (cur_hit)
    );

    generate
        if (PREFETCH != 0) begin : g_nxt
            jtdd_adpcm_fetch_slot #(.AW(AW)) u_nxt (
                .clk        (clk),
                .rst_n      (rst_n),
                .wr_i       (nxt_wr),
                .clr_i      (nxt_clr),
                .wr_tag_i   (nxt_wr_tag),
                .wr_byte_i  (nxt_wr_byte),
                .cmp_addr_i (addr),
                .tag_o      (nxt_tag),
                .byte_o     (nxt_byte),
                .valid_o    (nxt_valid),
                .hit_o      (nxt_hit)
            );
        end else begin : g_no_nxt
            logic unused_nxt;
            assign unused_nxt = ^{nxt_wr, nxt_clr, nxt_wr_tag, nxt_wr_byte};
            assign nxt_tag    = '0;
            assign nxt_byte   = '0;
            assign nxt_valid  = 1'b0;
            assign nxt_hit    = 1'b0;
        end
    endgenerate

    // Control registers: state, in-flight request (address doubles as its tag) and miss counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            kind_q     <= KIND_CUR;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            miss_q     <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            miss_q     <= miss_d;
        end
    end

    // Next-state logic: demand miss beats prefetch; promotion and the following prefetch use separate cycles.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        mem_addr_d  = mem_addr_q;
        mem_req_d   = mem_req_q;
        miss_d      = miss_q;
        cur_wr      = 1'b0;
        cur_clr     = 1'b0;
        cur_wr_tag  = mem_addr_q;
        cur_wr_byte = mem_data;
        nxt_wr      = 1'b0;
        nxt_clr     = 1'b0;
        nxt_wr_tag  = mem_addr_q;
        nxt_wr_byte = mem_data;

        case (state_q)
            ST_IDLE: begin
                if (cs) begin
                    if (!cur_hit) begin
                        if (nxt_hit) begin
                            cur_wr      = 1'b1;
                            cur_wr_tag  = nxt_tag;
                            cur_wr_byte = nxt_byte;
                            nxt_clr     = 1'b1;
                        end else begin
                            cur_clr    = 1'b1;
                            nxt_clr    = 1'b1;
                            mem_addr_d = addr;
                            mem_req_d  = 1'b1;
                            kind_d     = KIND_CUR;
                            state_d    = ST_FETCH;
                            if (miss_q != MISS_MAX) begin
                                miss_d = miss_q + 8'd1;
                            end
                        end
                    end else if ((PREFETCH != 0) && !nxt_valid && (nxt_tag != cur_inc)) begin
                        mem_addr_d = cur_inc;
                        mem_req_d  = 1'b1;
                        kind_d     = KIND_NXT;
                        state_d    = ST_FETCH;
                    end
                end
            end

            ST_FETCH: begin
                if (mem_dok) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                    if (mem_addr_q == addr) begin
                        cur_wr = 1'b1;
                    end else if ((kind_q == KIND_NXT) && (mem_addr_q == cur_inc)) begin
                        nxt_wr = 1'b1;
                    end
                end else if (kind_q == KIND_CUR) begin
                    if (addr != mem_addr_q) begin
                        state_d = ST_WAIT_DISCARD;
                    end
                end else if ((addr != mem_addr_q) && (addr != cur_tag)) begin
                    state_d = ST_WAIT_DISCARD;
                end
            end

            ST_WAIT_DISCARD: begin
                if (mem_dok) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign ok       = cur_hit;
    assign data     = cur_byte;
    assign mem_addr = mem_addr_q;
    assign mem_req  = mem_req_q;
    assign miss_cnt = miss_q;

endmodule

// File: tb/tb_jtdd_adpcm_fetch.sv
// Bench for the ADPCM fetch stage: directed scenarios plus a randomized run against a rule-level model.
module tb_jtdd_adpcm_fetch;

    // Free-running clock shared by both instances
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] addr;
    logic        cs;
    logic [7:0]  memData;
    logic        memDok;
    logic [7:0]  data;
    logic        ok;
    logic [15:0] memAddr;
    logic        memReq;
    logic [7:0]  missCnt;

    logic [15:0] p0Addr;
    logic        p0Cs;
    logic [7:0]  p0MemData;
    logic        p0MemDok;
    logic [7:0]  p0DataOut;
    logic        p0Ok;
    logic [15:0] p0MemAddr;
    logic        p0MemReq;
    logic [7:0]  p0Miss;

    int checks   = 0;
    int failures = 0;

    // Reference model: cached bytes, one outstanding request, miss count
    logic [15:0] mCurTag, mNxtTag, mReqAddr;
    logic [7:0]  mCurByte, mNxtByte, mMiss;
    bit          mCurVal, mNxtVal, mReqOn, mReqIsNxt, mReqDead;

    logic [15:0] tbAddr;
    logic        tbCs;
    int          memLat;
    int          latCnt;
    bit          pulseDok;
    int          r;

    jtdd_adpcm_fetch #(.AW(16), .PREFETCH(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .cs       (cs),
        .data     (data),
        .ok       (ok),
        .mem_addr (memAddr),
        .mem_req  (memReq),
        .mem_data (memData),
        .mem_dok  (memDok),
        .miss_cnt (missCnt)
    );

    jtdd_adpcm_fetch #(.AW(16), .PREFETCH(0)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (p0Addr),
        .cs       (p0Cs),
        .data     (p0DataOut),
        .ok       (p0Ok),
        .mem_addr (p0MemAddr),
        .mem_req  (p0MemReq),
        .mem_data (p0MemData),
        .mem_dok  (p0MemDok),
        .miss_cnt (p0Miss)
    );

    // ROM contents seen by the memory responder
    function automatic logic [7:0] memByte(input logic [15:0] a);
        if (a == 16'h1234) return 8'hA7;
        if (a == 16'h1235) return 8'h5C;
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        mCurTag = '0; mCurByte = '0; mCurVal = 0;
        mNxtTag = '0; mNxtByte = '0; mNxtVal = 0;
        mReqAddr = '0; mReqOn = 0; mReqIsNxt = 0; mReqDead = 0;
        mMiss = '0; latCnt = 0;
    endtask

    // Apply one clock edge's worth of the fetch rules to the model
    task automatic modelStep();
        logic [15:0] curInc;
        curInc = mCurTag + 16'd1;
        if (!mReqOn) begin
            if (cs) begin
                if (!(mCurVal && mCurTag == addr)) begin
                    if (mNxtVal && mNxtTag == addr) begin
                        mCurTag = mNxtTag; mCurByte = mNxtByte; mCurVal = 1; mNxtVal = 0;
                    end else begin
                        mCurVal = 0; mNxtVal = 0;
                        mReqOn = 1; mReqAddr = addr; mReqIsNxt = 0; mReqDead = 0;
                        latCnt = memLat - 1;
                        if (mMiss != 8'hFF) mMiss = mMiss + 8'd1;
                    end
                end else if (!mNxtVal && mNxtTag != curInc) begin
                    mReqOn = 1; mReqAddr = curInc; mReqIsNxt = 1; mReqDead = 0;
                    latCnt = memLat - 1;
                end
            end
        end else if (memDok) begin
            mReqOn = 0;
            if (!mReqDead) begin
                if (addr == mReqAddr) begin
                    mCurTag = mReqAddr; mCurByte = memData; mCurVal = 1;
                end else if (mReqIsNxt && mReqAddr == curInc) begin
                    mNxtTag = mReqAddr; mNxtByte = memData; mNxtVal = 1;
                end
            end
        end else if (!mReqDead) begin
            if (addr != mReqAddr && !(mReqIsNxt && addr == mCurTag)) mReqDead = 1;
        end
    endtask

    // One cycle: drive inputs and memory response at negedge, compare, then advance the model
    task automatic applyStimulus();
        logic expOk;
        @(negedge clk);
        memDok  = 1'b0;
        memData = 8'($urandom);
        if (mReqOn) begin
            if (latCnt <= 0) begin
                memDok  = 1'b1;
                memData = memByte(mReqAddr);
            end else begin
                latCnt--;
            end
        end else if (pulseDok) begin
            memDok   = 1'b1;
            pulseDok = 0;
        end
        addr = tbAddr;
        cs   = tbCs;
        #1;
        expOk = mCurVal && (mCurTag == addr);
        checkOutput("ok", 32'(ok), 32'(expOk));
        checkOutput("data", 32'(data), 32'(mCurByte));
        checkOutput("mem_req", 32'(memReq), 32'(mReqOn));
        checkOutput("mem_addr", 32'(memAddr), 32'(mReqAddr));
        checkOutput("miss_cnt", 32'(missCnt), 32'(mMiss));
        if (!rst_n) modelReset();
        else modelStep();
    endtask

    // Safety net so the run always ends
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        logic [15:0] p0Seq [3];
        p0Seq = '{16'h0010, 16'h0011, 16'h0012};
        rst_n = 1'b0; addr = '0; cs = 1'b0; memData = '0; memDok = 1'b0;
        p0Addr = '0; p0Cs = 1'b0; p0MemData = '0; p0MemDok = 1'b0;
        tbAddr = '0; tbCs = 1'b0; memLat = 1; pulseDok = 0;
        modelReset();
        #1;
        checkOutput("rst_data", 32'(data), 32'h0);
        checkOutput("rst_ok", 32'(ok), 32'h0);
        checkOutput("rst_mem_req", 32'(memReq), 32'h0);
        checkOutput("rst_mem_addr", 32'(memAddr), 32'h0);
        checkOutput("rst_miss", 32'(missCnt), 32'h0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Cold start with 5-cycle latency
        tbAddr = 16'h1234; tbCs = 1'b1; memLat = 5;
        applyStimulus();
        memLat = 3;
        applyStimulus();
        checkOutput("cold_mem_addr", 32'(memAddr), 32'h1234);
        checkOutput("cold_mem_req", 32'(memReq), 32'h1);
        repeat (6) applyStimulus();
        checkOutput("cold_ok", 32'(ok), 32'h1);
        checkOutput("cold_data", 32'(data), 32'hA7);
        checkOutput("cold_miss", 32'(missCnt), 32'h1);

        // Sequential step served from the prefetched byte
        repeat (20) applyStimulus();
        tbAddr = 16'h1235;
        applyStimulus();
        applyStimulus();
        checkOutput("seq_ok", 32'(ok), 32'h1);
        checkOutput("seq_data", 32'(data), 32'h5C);
        checkOutput("seq_miss", 32'(missCnt), 32'h1);
        applyStimulus();
        checkOutput("seq_pf_addr", 32'(memAddr), 32'h1236);
        checkOutput("seq_pf_req", 32'(memReq), 32'h1);
        repeat (10) applyStimulus();

        // Jump while a demand fetch is in flight
        tbAddr = 16'h0100; memLat = 6;
        repeat (3) applyStimulus();
        tbAddr = 16'h8000;
        repeat (20) applyStimulus();
        checkOutput("jump_ok", 32'(ok), 32'h1);
        checkOutput("jump_data", 32'(data), 32'(memByte(16'h8000)));
        checkOutput("jump_miss", 32'(missCnt), 32'h3);

        // Address wrap on prefetch
        tbAddr = 16'hFFFF; memLat = 20;
        repeat (25) applyStimulus();
        checkOutput("wrap_pf_req", 32'(memReq), 32'h1);
        checkOutput("wrap_pf_addr", 32'(memAddr), 32'h0000);
        repeat (20) applyStimulus();
        memLat = 10;
        tbAddr = 16'h0000;
        repeat (2) applyStimulus();
        checkOutput("wrap_ok", 32'(ok), 32'h1);
        checkOutput("wrap_miss", 32'(missCnt), 32'h4);

        // cs low with a prefetch outstanding
        tbCs = 1'b0;
        applyStimulus();
        checkOutput("csl_req_out", 32'(memReq), 32'h1);
        repeat (100) applyStimulus();
        checkOutput("csl_ok", 32'(ok), 32'h1);
        checkOutput("csl_req", 32'(memReq), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55) tbAddr = tbAddr;
            else if (r < 80) tbAddr = tbAddr + 16'd1;
            else if (r < 90) tbAddr = 16'($urandom);
            else if (r < 95) tbAddr = 16'hFFFE + 16'($urandom_range(0, 2));
            else tbAddr = tbAddr - 16'd1;
            tbCs   = ($urandom_range(0, 9) != 0);
            memLat = $urandom_range(1, 6);
            applyStimulus();
        end

        // Random address every cycle drives the miss counter into saturation
        tbCs = 1'b1; memLat = 1;
        for (int n = 0; n < 1500; n++) begin
            tbAddr = 16'($urandom);
            applyStimulus();
        end
        checkOutput("miss_sat", 32'(missCnt), 32'hFF);

        // Reset in the middle of a long fetch, then a late strobe
        tbAddr = 16'h4321; memLat = 50;
        repeat (15) applyStimulus();
        checkOutput("rmid_req", 32'(memReq), 32'h1);
        rst_n = 1'b0;
        tbCs  = 1'b0;
        #1;
        checkOutput("rmid_data", 32'(data), 32'h0);
        checkOutput("rmid_ok", 32'(ok), 32'h0);
        checkOutput("rmid_mem_req", 32'(memReq), 32'h0);
        checkOutput("rmid_mem_addr", 32'(memAddr), 32'h0);
        checkOutput("rmid_miss", 32'(missCnt), 32'h0);
        modelReset();
        repeat (3) applyStimulus();
        rst_n = 1'b1;
        pulseDok = 1;
        repeat (3) applyStimulus();
        checkOutput("late_ok", 32'(ok), 32'h0);
        checkOutput("late_req", 32'(memReq), 32'h0);
        checkOutput("late_data", 32'(data), 32'h0);

        // On-demand-only instance: three sequential addresses are three misses
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            p0Addr = p0Seq[k];
            p0Cs   = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (p0MemReq) break;
            end
            #1;
            checkOutput("p0_req", 32'(p0MemReq), 32'h1);
            checkOutput("p0_mem_addr", 32'(p0MemAddr), 32'(p0Seq[k]));
            @(negedge clk);
            p0MemDok  = 1'b1;
            p0MemData = 8'hC0 ^ p0Seq[k][7:0];
            @(negedge clk);
            p0MemDok  = 1'b0;
            #1;
            checkOutput("p0_ok", 32'(p0Ok), 32'h1);
            checkOutput("p0_data", 32'(p0DataOut), 32'(8'hC0 ^ p0Seq[k][7:0]));
        end
        repeat (10) @(negedge clk);
        #1;
        checkOutput("p0_no_pf", 32'(p0MemReq), 32'h0);
        checkOutput("p0_miss", 32'(p0Miss), 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtdd_adpcm_fetch.md
Name: jtdd_adpcm_fetch

Overview:
- Upstream ROM-fetch stage that feeds the ADPCM decoder's byte port (rom_addr/rom_cs/rom_data/rom_ok) from the shared SDRAM sample-ROM channel.
- The decoder's byte address advances once every two 4-bit samples, so the block holds the current byte and prefetches the next sequential byte.
- Most address steps therefore hit with zero stall.
- A small saturating miss counter is provided for debug and sign-off.

Parameters:
- AW, 16, byte-address width on both sides.
- PREFETCH, 1, 1 enables the next-byte slot; 0 fetches on demand only.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  AW  byte address requested by the ADPCM decoder.
- cs  in  1  decoder request enable; when low, no new fetches start.
- data  out  8  byte for addr; registered.
- ok  out  1  data is valid for the current addr.
- mem_addr  out  AW  SDRAM channel address.
- mem_req  out  1  request, held high until mem_dok.
- mem_data  in  8  SDRAM read data.
- mem_dok  in  1  one-cycle strobe: mem_data valid for mem_addr; may arrive 1..N cycles after mem_req rises.
- miss_cnt  out  8  saturating count of demand misses.

Behaviour:
- Reset values: data=0, ok=0, mem_req=0, mem_addr=0, miss_cnt=0, both slot valids=0, state=IDLE.
- Reset may assert mid-fetch. A mem_dok arriving after reset release with no request outstanding is ignored.
- Storage:
  - Slot CUR: tag[AW], byte, valid.
  - Slot NXT: tag[AW], byte, valid. Present only if PREFETCH=1.
  - Inflight tag register: tag[AW] plus a kind bit (CUR or NXT).
- ok is combinational: CUR.valid && CUR.tag==addr. An addr change drops ok in the same cycle, so the decoder never latches stale data.
- data = CUR.byte.
- States: IDLE, FETCH, WAIT_DISCARD.
- IDLE, cs=1 and ok=0:
  - If NXT.valid && NXT.tag==addr, promote NXT to CUR (ok rises the next cycle) and clear NXT.valid.
  - Otherwise it is a demand miss: invalidate CUR and NXT, set mem_addr=addr, mem_req=1, kind=CUR, go to FETCH, and increment miss_cnt, saturating at 255.
- IDLE, cs=1, ok=1, PREFETCH=1, NXT invalid, and NXT.tag != CUR.tag+1 (wraps modulo 2^AW, so 0xFFFF→0x0000):
  - Launch a prefetch: mem_addr=CUR.tag+1, kind=NXT, mem_req=1, go to FETCH.
- FETCH, on mem_dok: mem_req drops the same edge.
  - kind=CUR and inflight tag==addr: write CUR. ok is high the cycle after mem_dok.
  - kind=NXT and inflight tag==CUR.tag+1: write NXT.
  - Otherwise discard the byte. Go to IDLE.
- FETCH, addr changes before mem_dok (stale request):
  - The SDRAM request cannot be cancelled. Go to WAIT_DISCARD and keep mem_req high.
  - On mem_dok, discard the byte and go to IDLE. IDLE then re-evaluates the new addr.
  - Exception: a change to exactly the inflight tag of a NXT fetch (sequential step during prefetch) stays in FETCH. The returning byte is written to CUR directly and counts as a hit.
- Priority: demand miss before prefetch. Promotion from NXT and launching the next prefetch take separate cycles.
- cs=0: no new request starts. An in-flight request completes normally. ok/data continue to reflect addr.
- mem_addr is stable for the whole time mem_req is high.

Decomposition:
- No package needed. The states IDLE/FETCH/WAIT_DISCARD are a local 2-bit encoding.
- One natural sub-module: jtdd_adpcm_fetch_slot (tag/byte/valid register with compare output), instantiated twice. NXT is tied off when PREFETCH=0.

Test Plan:
- Cold start: reset, cs=1, addr=0x1234, mem_dok 5 cycles after mem_req with 0xA7 -> mem_addr=0x1234; ok=1, data=0xA7 the cycle after mem_dok; miss_cnt=1.
- Sequential prefetch, 3-cycle memory latency: after the cold fetch, the block prefetches 0x1235. Drive mem_data=0x5C. Step addr to 0x1235 20 cycles later -> ok=1 one cycle after the step; miss_cnt stays 1; a new request for 0x1236 follows.
- Jump mid-flight:
  - Stimulus: demand fetch of 0x0100 outstanding; addr changes to 0x8000 before mem_dok.
  - Response: the 0x0100 byte is discarded and ok stays 0; a new request with mem_addr=0x8000 follows; miss_cnt increments by 2 in total.
- Wrap: CUR.tag=0xFFFF valid, PREFETCH=1 -> prefetch mem_addr=0x0000; addr=0x0000 hits with no miss.
- cs low: cs=0 with a prefetch outstanding -> it completes; no further mem_req for 100 cycles; ok holds 1 for an unchanged addr.
- Reset mid-fetch and PREFETCH=0:
  - Reset: rst_n low while mem_req=1 -> outputs at reset values; a late mem_dok is ignored.
  - PREFETCH=0: addr sequence 0x10, 0x11, 0x12 -> three demand misses; miss_cnt=3.
